idex_stage: RTL and testbench

- Decode-to-execute pipeline register with valid/ready handshake.
- Captures the decoded instruction together with the forwarded operands (rs1/rs2) produced by the bypass/regfile block.
- Inserts a bubble when the load-use hazard signal is raised and drops its contents on flush.
- Its outputs feed the EXU and feed back into the bypass block as the EX-stage forwarding/hazard sources (ex valid, rd id, rd write-enable, load flag, ld-st bypass flag, rs2).

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/idex_perf_cnt.sv | 35 +++
 rtl/idex_stage.sv | 125 ++++++++++++
 tb/tb_idex_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: core widths and the ID->EX payload struct.
// Widths: CPU_WIDTH (operand/PC), REG_ADDRW (register index), INST_WIDTH (raw
// instruction), ALUOP_WIDTH (function select). idex_payload_t is reused by IDU/EXU.
package cpu_pkg;

    localparam int unsigned CPU_WIDTH   = 64;
    localparam int unsigned REG_ADDRW   = 5;
    localparam int unsigned INST_WIDTH  = 32;
    localparam int unsigned ALUOP_WIDTH = 8;

    typedef struct packed {
        logic [CPU_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0]  inst;
        logic [CPU_WIDTH-1:0]   rs1;
        logic [CPU_WIDTH-1:0]   rs2;
        logic [CPU_WIDTH-1:0]   imm;
        logic [ALUOP_WIDTH-1:0] aluop;
        logic [REG_ADDRW-1:0]   rdid;
        logic                   rdwen;
        logic                   lden;
        logic                   sten;
        logic                   ldstbp;
    } idex_payload_t;

endpackage

// File: rtl/idex_perf_cnt.sv
// ID/EX performance counters: three 64-bit saturating event counters.
// Ports: i_clk, i_rst_n (async active-low); i_bubble_evt / i_stall_evt /
// i_flush_evt one-cycle event strobes; o_bubble_cnt / o_stall_cnt / o_flush_cnt
// counts. Only instantiated when IDEX_PERF_CNT_EN is defined.
module idex_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bubble_evt,
    input  logic        i_stall_evt,
    input  logic        i_flush_evt,
    output logic [63:0] o_bubble_cnt,
    output logic [63:0] o_stall_cnt,
    output logic [63:0] o_flush_cnt
);

    logic [63:0] bubble_q, stall_q, flush_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            if (i_bubble_evt && (bubble_q != '1)) bubble_q <= bubble_q + 64'd1;
            if (i_stall_evt  && (stall_q  != '1)) stall_q  <= stall_q  + 64'd1;
            if (i_flush_evt  && (flush_q  != '1)) flush_q  <= flush_q  + 64'd1;
        end
    end

    assign o_bubble_cnt = bubble_q;
    assign o_stall_cnt  = stall_q;
    assign o_flush_cnt  = flush_q;

endmodule

// File: rtl/idex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake.
// Captures the decoded instruction plus forwarded rs1/rs2; inserts a bubble on
// i_bubble (load-use) and empties on i_flush. EX-side outputs also feed the
// bypass block as forwarding/hazard sources; payload is qualified by o_ex_valid.
// Ports: i_clk, i_rst_n (async active-low), i_flush, i_bubble,
//   i_id_valid/o_id_ready (ID handshake), o_ex_valid/i_ex_ready (EX handshake),
//   i_pc..i_ldstbp payload in, o_ex_pc..o_ex_ldstbp registered payload out.
// Optional: define IDEX_PERF_CNT_EN to add o_bubble_cnt/o_stall_cnt/o_flush_cnt.
module idex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN    = CPU_WIDTH,
    parameter int unsigned REG_AW  = REG_ADDRW,
    parameter int unsigned INST_W  = INST_WIDTH,
    parameter int unsigned ALUOP_W = ALUOP_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_bubble,
    input  logic               i_id_valid,
    output logic               o_id_ready,
    output logic               o_ex_valid,
    input  logic               i_ex_ready,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [INST_W-1:0]  i_inst,
    input  logic [XLEN-1:0]    i_rs1,
    input  logic [XLEN-1:0]    i_rs2,
    input  logic [XLEN-1:0]    i_imm,
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [REG_AW-1:0]  i_rdid,
    input  logic               i_rdwen,
    input  logic               i_lden,
    input  logic               i_sten,
    input  logic               i_ldstbp,
    output logic [XLEN-1:0]    o_ex_pc,
    output logic [INST_W-1:0]  o_ex_inst,
    output logic [XLEN-1:0]    o_ex_rs1,
    output logic [XLEN-1:0]    o_ex_rs2,
    output logic [XLEN-1:0]    o_ex_imm,
    output logic [ALUOP_W-1:0] o_ex_aluop,
    output logic [REG_AW-1:0]  o_ex_rdid,
    output logic               o_ex_rdwen,
    output logic               o_ex_lden,
    output logic               o_ex_sten,
    output logic               o_ex_ldstbp
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [63:0]        o_bubble_cnt,
    output logic [63:0]        o_stall_cnt,
    output logic [63:0]        o_flush_cnt
`endif
);

    logic          valid_q;
    logic          en;
    logic          acc;
    idex_payload_t payload_d, payload_q;

    assign en         = !valid_q || i_ex_ready;
    assign o_id_ready = en && !i_bubble && !i_flush;
    assign acc        = i_id_valid && o_id_ready;

    always_comb begin
        payload_d        = payload_q;
        payload_d.pc     = i_pc;
        payload_d.inst   = i_inst;
        payload_d.rs1    = i_rs1;
        payload_d.rs2    = i_rs2;
        payload_d.imm    = i_imm;
        payload_d.aluop  = i_aluop;
        payload_d.rdid   = i_rdid;
        // x0 is never a forwarding source.
        payload_d.rdwen  = i_rdwen && (i_rdid != '0);
        payload_d.lden   = i_lden;
        payload_d.sten   = i_sten;
        payload_d.ldstbp = i_ldstbp;
    end

    // Flush beats everything, including backpressure; a bubble with en loads empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= acc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            payload_q <= '0;
        end else if (acc) begin
            payload_q <= payload_d;
        end
    end

    assign o_ex_valid  = valid_q;
    assign o_ex_pc     = payload_q.pc;
    assign o_ex_inst   = payload_q.inst;
    assign o_ex_rs1    = payload_q.rs1;
    assign o_ex_rs2    = payload_q.rs2;
    assign o_ex_imm    = payload_q.imm;
    assign o_ex_aluop  = payload_q.aluop;
    assign o_ex_rdid   = payload_q.rdid;
    assign o_ex_rdwen  = payload_q.rdwen;
    assign o_ex_lden   = payload_q.lden;
    assign o_ex_sten   = payload_q.sten;
    assign o_ex_ldstbp = payload_q.ldstbp;

`ifdef IDEX_PERF_CNT_EN
    idex_perf_cnt u_perf_cnt (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_bubble_evt (en && i_bubble && i_id_valid && !i_flush),
        .i_stall_evt  (valid_q && !i_ex_ready),
        .i_flush_evt  (i_flush && valid_q),
        .o_bubble_cnt (o_bubble_cnt),
        .o_stall_cnt  (o_stall_cnt),
        .o_flush_cnt  (o_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: reset, handshake, backpressure, bubble, flush
// priority, x0 rule and (with IDEX_PERF_CNT_EN) the perf counters.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, bubble, id_valid, id_ready, ex_valid, ex_ready;
    logic [63:0] pc, rs1, rs2, imm;
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [4:0]  rdid;
    logic        rdwen, lden, sten, ldstbp;
    logic [63:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [31:0] ex_inst;
    logic [7:0]  ex_aluop;
    logic [4:0]  ex_rdid;
    logic        ex_rdwen, ex_lden, ex_sten, ex_ldstbp;
`ifdef IDEX_PERF_CNT_EN
    logic [63:0] bubble_cnt, stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idex_stage dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_bubble    (bubble),
        .i_id_valid  (id_valid),
        .o_id_ready  (id_ready),
        .o_ex_valid  (ex_valid),
        .i_ex_ready  (ex_ready),
        .i_pc        (pc),
        .i_inst      (inst),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .i_imm       (imm),
        .i_aluop     (aluop),
        .i_rdid      (rdid),
        .i_rdwen     (rdwen),
        .i_lden      (lden),
        .i_sten      (sten),
        .i_ldstbp    (ldstbp),
        .o_ex_pc     (ex_pc),
        .o_ex_inst   (ex_inst),
        .o_ex_rs1    (ex_rs1),
        .o_ex_rs2    (ex_rs2),
        .o_ex_imm    (ex_imm),
        .o_ex_aluop  (ex_aluop),
        .o_ex_rdid   (ex_rdid),
        .o_ex_rdwen  (ex_rdwen),
        .o_ex_lden   (ex_lden),
        .o_ex_sten   (ex_sten),
        .o_ex_ldstbp (ex_ldstbp)
`ifdef IDEX_PERF_CNT_EN
        ,
        .o_bubble_cnt (bubble_cnt),
        .o_stall_cnt  (stall_cnt),
        .o_flush_cnt  (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; bubble = 0; id_valid = 0; ex_ready = 0;
        pc = '0; inst = '0; rs1 = '0; rs2 = '0; imm = '0; aluop = '0;
        rdid = '0; rdwen = 0; lden = 0; sten = 0; ldstbp = 0;
        #1;
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_pc", ex_pc, 64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // First accept after reset.
        id_valid = 1; ex_ready = 1; rs1 = 64'h1234; pc = 64'h100;
        #1 check("first_ready", 64'(id_ready), 64'd1);
        tick();
        check("first_valid", 64'(ex_valid), 64'd1);
        check("first_rs1", ex_rs1, 64'h1234);

        // Asynchronous reset mid-cycle with a valid slot.
        id_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(ex_valid), 64'd0);
        check("async_rst_rs1", ex_rs1, 64'd0);
        #1 rst_n = 1'b1;

        // Backpressure: payload holds while EXU stalls.
        tick();
        id_valid = 1; ex_ready = 1; pc = 64'h8000_0000; inst = 32'h0000_0013;
        tick();
        check("bp_load_pc", ex_pc, 64'h8000_0000);
        check("bp_load_inst", 64'(ex_inst), 64'h13);
        ex_ready = 0; pc = 64'h8000_0004; inst = 32'h0010_0093;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready_low", 64'(id_ready), 64'd0);
            tick();
            check("bp_pc_hold", ex_pc, 64'h8000_0000);
            check("bp_valid_hold", 64'(ex_valid), 64'd1);
        end
        ex_ready = 1;
        #1 check("bp_release_ready", 64'(id_ready), 64'd1);
        tick();
        check("bp_next_pc", ex_pc, 64'h8000_0004);

        // Load-use bubble: EXU retires, ID held back.
        bubble = 1; rs2 = 64'hdead; pc = 64'h8000_0008;
        #1 check("bub_ready_low", 64'(id_ready), 64'd0);
        tick();
        check("bub_valid_empty", 64'(ex_valid), 64'd0);
        check("bub_pc_hold", ex_pc, 64'h8000_0004);
        bubble = 0;
        #1 check("bub_drop_ready", 64'(id_ready), 64'd1);
        tick();
        check("bub_accept_valid", 64'(ex_valid), 64'd1);
        check("bub_accept_rs2", ex_rs2, 64'hdead);

        // Flush beats backpressure.
        ex_ready = 0; flush = 1; pc = 64'h8000_000c;
        #1 check("flush_ready_low", 64'(id_ready), 64'd0);
        tick();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_pc_hold", ex_pc, 64'h8000_0008);
        flush = 0;

        // x0 rule and flag capture.
        ex_ready = 1; rdid = 5'd0; rdwen = 1; lden = 1; sten = 0; ldstbp = 1;
        imm = 64'hffff_fff0; aluop = 8'h5a;
        tick();
        check("x0_rdwen", 64'(ex_rdwen), 64'd0);
        check("x0_lden", 64'(ex_lden), 64'd1);
        check("x0_ldstbp", 64'(ex_ldstbp), 64'd1);
        check("x0_imm", ex_imm, 64'hffff_fff0);
        check("x0_aluop", 64'(ex_aluop), 64'h5a);
        rdid = 5'd5; lden = 0; sten = 1; ldstbp = 0;
        tick();
        check("x5_rdwen", 64'(ex_rdwen), 64'd1);
        check("x5_rdid", 64'(ex_rdid), 64'd5);
        check("x5_sten", 64'(ex_sten), 64'd1);
        check("x5_lden", 64'(ex_lden), 64'd0);

`ifdef IDEX_PERF_CNT_EN
        // Clean counters, then 4 bubble, 2 stall, 1 flush-of-valid cycles.
        id_valid = 0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        check("perf_rst", bubble_cnt | stall_cnt | flush_cnt, 64'd0);
        id_valid = 1; bubble = 1; ex_ready = 1;
        repeat (4) tick();
        bubble = 0;
        tick();
        id_valid = 0; ex_ready = 0;
        repeat (2) tick();
        ex_ready = 1; flush = 1;
        tick();
        flush = 0;
        check("perf_bubble", bubble_cnt, 64'd4);
        check("perf_stall", stall_cnt, 64'd2);
        check("perf_flush", flush_cnt, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
